id_exe_stage_reg: RTL and testbench

- Pipeline register between the instruction-decode stage (control unit + register file) and the execute stage of the five-stage ARM core.
- Captures the decoded control word (exe_cmd, mem_r_en, mem_w_en, wb_en, s, b), operands, immediates and register tags each cycle.
- Supports freeze for hazard stalls, flush for taken branches, and a valid bit so downstream stages can ignore bubbles.

---
 rtl/id_exe_stage_reg.sv | 124 ++++++++++++
 tb/tb_id_exe_stage_reg.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_stage_reg.sv
// ID/EX pipeline register for the five-stage ARM core.
// Captures the decoded control word, operands, immediates and tags; supports flush, freeze and bubbles.
module id_exe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             freeze,
  input  logic             valid_in,
  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             b_in,
  input  logic             s_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic             imm_in,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] val_rn_in,
  input  logic [WIDTH-1:0] val_rm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm_24_in,
  input  logic [TAG_W-1:0] dest_in,
  input  logic [TAG_W-1:0] src1_in,
  input  logic [TAG_W-1:0] src2_in,
  output logic             valid_out,
  output logic             wb_en_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic             b_out,
  output logic             s_out,
  output logic [3:0]       exe_cmd_out,
  output logic             imm_out,
  output logic             carry_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] val_rn_out,
  output logic [WIDTH-1:0] val_rm_out,
  output logic [11:0]      shift_operand_out,
  output logic [23:0]      signed_imm_24_out,
  output logic [TAG_W-1:0] dest_out,
  output logic [TAG_W-1:0] src1_out,
  output logic [TAG_W-1:0] src2_out
);

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             b;
    logic             s;
    logic [3:0]       exe_cmd;
    logic             imm;
    logic             carry;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] val_rn;
    logic [WIDTH-1:0] val_rm;
    logic [11:0]      shift_operand;
    logic [23:0]      signed_imm_24;
    logic [TAG_W-1:0] dest;
    logic [TAG_W-1:0] src1;
    logic [TAG_W-1:0] src2;
  } stage_t;

  stage_t stage_q;
  stage_t stage_d;
  logic   live;

  // A simultaneous read+write decode is illegal; treat it like a bubble.
  assign live = valid_in & ~(mem_r_en_in & mem_w_en_in);

  always_comb begin
    stage_d               = '0;
    stage_d.valid         = live;
    stage_d.wb_en         = live & wb_en_in;
    stage_d.mem_r_en      = live & mem_r_en_in;
    stage_d.mem_w_en      = live & mem_w_en_in;
    stage_d.b             = live & b_in;
    stage_d.s             = live & s_in;
    // Branch decodes leave exe_cmd undefined; a mux keeps X out of execute.
    stage_d.exe_cmd       = (live && !b_in) ? exe_cmd_in : 4'b0000;
    stage_d.imm           = imm_in;
    stage_d.carry         = carry_in;
    stage_d.pc            = pc_in;
    stage_d.val_rn        = val_rn_in;
    stage_d.val_rm        = val_rm_in;
    stage_d.shift_operand = shift_operand_in;
    stage_d.signed_imm_24 = signed_imm_24_in;
    stage_d.dest          = dest_in;
    stage_d.src1          = src1_in;
    stage_d.src2          = src2_in;
  end

  // Flush wins over freeze so a stalled instruction can still be squashed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stage_q <= '0;
    else if (flush)
      stage_q <= '0;
    else if (!freeze)
      stage_q <= stage_d;
  end

  assign valid_out         = stage_q.valid;
  assign wb_en_out         = stage_q.wb_en;
  assign mem_r_en_out      = stage_q.mem_r_en;
  assign mem_w_en_out      = stage_q.mem_w_en;
  assign b_out             = stage_q.b;
  assign s_out             = stage_q.s;
  assign exe_cmd_out       = stage_q.exe_cmd;
  assign imm_out           = stage_q.imm;
  assign carry_out         = stage_q.carry;
  assign pc_out            = stage_q.pc;
  assign val_rn_out        = stage_q.val_rn;
  assign val_rm_out        = stage_q.val_rm;
  assign shift_operand_out = stage_q.shift_operand;
  assign signed_imm_24_out = stage_q.signed_imm_24;
  assign dest_out          = stage_q.dest;
  assign src1_out          = stage_q.src1;
  assign src2_out          = stage_q.src2;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed self-checking bench for id_exe_stage_reg.
// Each task drives one scenario and compares against hand-computed values.
module tb_id_exe_stage_reg;

  logic        clk, rst, flush, freeze, valid_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, carry_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in, src1_in, src2_in;

  logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, carry_out;
  logic [3:0]  exe_cmd_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic [3:0]  dest_out, src1_out, src2_out;

  logic [155:0] all_out;
  logic [9:0]   ctrl_out;
  assign all_out  = {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out,
                     imm_out, carry_out, pc_out, val_rn_out, val_rm_out, shift_operand_out,
                     signed_imm_24_out, dest_out, src1_out, src2_out};
  assign ctrl_out = {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out};

  int vec_cnt = 0;
  int err_cnt = 0;

  id_exe_stage_reg #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(valid_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .imm_in(imm_in), .carry_in(carry_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
    .valid_out(valid_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out),
    .imm_out(imm_out), .carry_out(carry_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
    .val_rm_out(val_rm_out), .shift_operand_out(shift_operand_out),
    .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out), .src1_out(src1_out),
    .src2_out(src2_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    flush = 0; freeze = 0; valid_in = 0;
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0;
    exe_cmd_in = 4'b0000; imm_in = 0; carry_in = 0;
    pc_in = '0; val_rn_in = '0; val_rm_in = '0;
    shift_operand_in = '0; signed_imm_24_in = '0;
    dest_in = '0; src1_in = '0; src2_in = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_add();
    clear_inputs();
    valid_in = 1; exe_cmd_in = 4'b0011; wb_en_in = 1; s_in = 1;
    val_rn_in = 32'd5; val_rm_in = 32'd7; dest_in = 4'd3; src1_in = 4'd1; src2_in = 4'd2;
    pc_in = 32'h0000_0020; shift_operand_in = 12'h007;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    #2;
    vec_cnt++;
    if (all_out !== '0) begin
      err_cnt++; $display("FAIL reset_initial outputs got %h expected 0", all_out);
    end
    step();
    rst = 1;
    valid_in = 1; pc_in = 32'h0000_0010; wb_en_in = 1; exe_cmd_in = 4'b0010;
    step();
    vec_cnt++;
    if ({valid_out, wb_en_out, exe_cmd_out, pc_out} !== {1'b1, 1'b1, 4'b0010, 32'h0000_0010}) begin
      err_cnt++;
      $display("FAIL reset_preload got v=%b wb=%b cmd=%b pc=%h expected v=1 wb=1 cmd=0010 pc=00000010",
               valid_out, wb_en_out, exe_cmd_out, pc_out);
    end
    rst = 0;
    #1;
    vec_cnt++;
    if (all_out !== '0) begin
      err_cnt++; $display("FAIL reset_async outputs got %h expected 0", all_out);
    end
    #1;
    rst = 1;
    pc_in = 32'h0000_0014; exe_cmd_in = 4'b0100; wb_en_in = 0;
    step();
    vec_cnt++;
    if ({valid_out, wb_en_out, exe_cmd_out, pc_out} !== {1'b1, 1'b0, 4'b0100, 32'h0000_0014}) begin
      err_cnt++;
      $display("FAIL reset_release got v=%b wb=%b cmd=%b pc=%h expected v=1 wb=0 cmd=0100 pc=00000014",
               valid_out, wb_en_out, exe_cmd_out, pc_out);
    end
  endtask

  task automatic test_load();
    drive_add();
    step();
    vec_cnt++;
    if (ctrl_out !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0011}) begin
      err_cnt++; $display("FAIL load_ctrl got %b expected 1100010011", ctrl_out);
    end
    vec_cnt++;
    if ({val_rn_out, val_rm_out, dest_out, src1_out, src2_out, pc_out, shift_operand_out} !==
        {32'd5, 32'd7, 4'd3, 4'd1, 4'd2, 32'h0000_0020, 12'h007}) begin
      err_cnt++;
      $display("FAIL load_data got rn=%0d rm=%0d dest=%0d pc=%h expected rn=5 rm=7 dest=3 pc=00000020",
               val_rn_out, val_rm_out, dest_out, pc_out);
    end
  endtask

  task automatic test_freeze();
    clear_inputs();
    freeze = 1; valid_in = 1; exe_cmd_in = 4'b0010; mem_w_en_in = 1;
    val_rn_in = 32'd100; val_rm_in = 32'd9; dest_in = 4'd6; imm_in = 1; carry_in = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      vec_cnt++;
      if ({ctrl_out, val_rn_out, val_rm_out, dest_out, imm_out, carry_out} !==
          {10'b1100010011, 32'd5, 32'd7, 4'd3, 1'b0, 1'b0}) begin
        err_cnt++;
        $display("FAIL freeze_hold[%0d] got ctrl=%b rn=%0d rm=%0d dest=%0d expected ctrl=1100010011 rn=5 rm=7 dest=3",
                 i, ctrl_out, val_rn_out, val_rm_out, dest_out);
      end
      val_rn_in = val_rn_in + 32'd1;
    end
    freeze = 0;
    step();
    vec_cnt++;
    if ({ctrl_out, val_rn_out, dest_out, imm_out, carry_out} !==
        {10'b1001000010, 32'd103, 4'd6, 1'b1, 1'b1}) begin
      err_cnt++;
      $display("FAIL freeze_release got ctrl=%b rn=%0d dest=%0d expected ctrl=1001000010 rn=103 dest=6",
               ctrl_out, val_rn_out, dest_out);
    end
  endtask

  task automatic test_flush();
    clear_inputs();
    valid_in = 1; exe_cmd_in = 4'b0010; mem_r_en_in = 1; wb_en_in = 1;
    val_rn_in = 32'hDEAD_BEEF; val_rm_in = 32'h1234; dest_in = 4'd9; pc_in = 32'h40;
    flush = 1; freeze = 1;
    step();
    vec_cnt++;
    if (all_out !== '0) begin
      err_cnt++; $display("FAIL flush_priority outputs got %h expected 0", all_out);
    end
    flush = 0; freeze = 1;
    step();
    vec_cnt++;
    if (all_out !== '0) begin
      err_cnt++; $display("FAIL flush_then_freeze outputs got %h expected 0", all_out);
    end
    freeze = 0;
    step();
    vec_cnt++;
    if ({ctrl_out, val_rn_out, dest_out} !== {10'b1110000010, 32'hDEAD_BEEF, 4'd9}) begin
      err_cnt++;
      $display("FAIL flush_reload got ctrl=%b rn=%h dest=%0d expected ctrl=1110000010 rn=deadbeef dest=9",
               ctrl_out, val_rn_out, dest_out);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    valid_in = 1; b_in = 1; exe_cmd_in = 4'bxxxx; signed_imm_24_in = 24'hFFFFFE; pc_in = 32'h0000_0104;
    step();
    vec_cnt++;
    if ({exe_cmd_out, b_out, valid_out} !== {4'b0000, 1'b1, 1'b1}) begin
      err_cnt++;
      $display("FAIL branch_ctrl got cmd=%b b=%b v=%b expected cmd=0000 b=1 v=1", exe_cmd_out, b_out, valid_out);
    end
    vec_cnt++;
    if ({signed_imm_24_out, pc_out} !== {24'hFFFFFE, 32'h0000_0104}) begin
      err_cnt++;
      $display("FAIL branch_imm got imm=%h pc=%h expected imm=fffffe pc=00000104", signed_imm_24_out, pc_out);
    end
    vec_cnt++;
    if (^all_out === 1'bx) begin
      err_cnt++; $display("FAIL branch_no_x outputs got %h expected no X", all_out);
    end
  endtask

  task automatic test_bubble();
    clear_inputs();
    valid_in = 1; mem_r_en_in = 1; mem_w_en_in = 1; wb_en_in = 1; s_in = 1;
    exe_cmd_in = 4'b0110; pc_in = 32'h0000_0200; val_rn_in = 32'd11;
    step();
    vec_cnt++;
    if (ctrl_out !== '0) begin
      err_cnt++; $display("FAIL illegal_rw ctrl got %b expected 0000000000", ctrl_out);
    end
    vec_cnt++;
    if ({pc_out, val_rn_out} !== {32'h0000_0200, 32'd11}) begin
      err_cnt++; $display("FAIL illegal_rw_data got pc=%h rn=%0d expected pc=00000200 rn=11", pc_out, val_rn_out);
    end
    clear_inputs();
    valid_in = 0; wb_en_in = 1; b_in = 1; exe_cmd_in = 4'b1001; dest_in = 4'd12; val_rm_in = 32'd77;
    step();
    vec_cnt++;
    if (ctrl_out !== '0) begin
      err_cnt++; $display("FAIL bubble_ctrl got %b expected 0000000000", ctrl_out);
    end
    vec_cnt++;
    if ({dest_out, val_rm_out} !== {4'd12, 32'd77}) begin
      err_cnt++; $display("FAIL bubble_data got dest=%0d rm=%0d expected dest=12 rm=77", dest_out, val_rm_out);
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      valid_in = 1; wb_en_in = 1; exe_cmd_in = 4'(i + 1);
      pc_in = 32'h1000 + 32'(4 * i); dest_in = 4'(i + 8);
      step();
      vec_cnt++;
      if ({valid_out, wb_en_out, exe_cmd_out, pc_out, dest_out} !==
          {1'b1, 1'b1, 4'(i + 1), 32'h1000 + 32'(4 * i), 4'(i + 8)}) begin
        err_cnt++;
        $display("FAIL b2b[%0d] got cmd=%b pc=%h dest=%0d expected cmd=%b pc=%h dest=%0d",
                 i, exe_cmd_out, pc_out, dest_out, 4'(i + 1), 32'h1000 + 32'(4 * i), i + 8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_freeze();
    test_flush();
    test_branch();
    test_bubble();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
